// File: rtl/my_ifetch.sv
// my_ifetch: instruction fetch stage feeding the decoder.
// Owns the PC, issues word-aligned req/gnt/rvalid fetches and buffers returned
// words in an in-order FIFO presented with valid/ready. A redirect flushes the
// buffer and drops responses still in flight.
// Optional feature: define IFETCH_ALIGN_CHECK_EN to flag a misaligned redirect
// target on fetch_err_o and halt fetching until an aligned redirect arrives.
module my_ifetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] pc_o,
  output logic        fetch_err_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Reject depths the pointer arithmetic cannot wrap correctly.
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("my_ifetch: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] outst_q, outst_d;
  logic [CNT_W-1:0] discard_q, discard_d;
  logic [31:0]      fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]      fifo_pc_d   [FIFO_DEPTH];
  logic [31:0]      fifo_inst_q [FIFO_DEPTH];
  logic [31:0]      fifo_inst_d [FIFO_DEPTH];

  logic             err_halt;
  logic             empty;
  logic             full;
  logic             pop;
  logic             push;
  logic             grant;
  logic             rsp_ok;
  logic [SUM_W-1:0] demand;
  logic [31:0]      rsp_pc;
  logic [31:0]      redirect_tgt;

  // Redirect target is always forced to a word boundary for the fetch address.
  assign redirect_tgt = {redirect_pc_i[31:2], 2'b00};

`ifdef IFETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  // Sticky misalignment flag, re-evaluated on every redirect.
  always_comb begin : comb_err
    err_d = err_q;
    if (redirect_i) begin
      err_d = (redirect_pc_i[1:0] != 2'b00);
    end
  end

  // Misalignment flag register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin : seq_err
    if (!rst_n_i) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_halt    = err_q;
  assign fetch_err_o = err_q;
`else
  logic unused_pc_lsb;

  assign unused_pc_lsb = ^redirect_pc_i[1:0];
  assign err_halt      = 1'b0;
  assign fetch_err_o   = 1'b0;
`endif

  // Output handshake, request gating and response classification.
  always_comb begin : comb_status
    empty        = (count_q == '0);
    full         = (count_q == CNT_W'(FIFO_DEPTH));
    inst_valid_o = !empty && !redirect_i;
    pop          = inst_valid_o && id_ready_i;
    inst_o       = NOP_INST;
    pc_o         = 32'h0000_0000;
    if (inst_valid_o) begin
      inst_o = fifo_inst_q[rptr_q];
      pc_o   = fifo_pc_q[rptr_q];
    end
    // Every granted request must own a FIFO slot when its response lands.
    demand      = SUM_W'(count_q) + SUM_W'(outst_q) - SUM_W'(pop);
    imem_req_o  = rst_n_i && !redirect_i && !err_halt && (demand < SUM_W'(FIFO_DEPTH));
    imem_addr_o = fetch_pc_q;
    grant       = imem_req_o && imem_gnt_i;
    // Responses with nothing outstanding are protocol violations and ignored.
    rsp_ok      = imem_rvalid_i && (outst_q != '0);
    // Oldest live request address: no discards pending means all in flight are live.
    rsp_pc      = fetch_pc_q - 32'({outst_q, 2'b00});
    push        = rsp_ok && (discard_q == '0) && !redirect_i && (!full || pop);
  end

  // Next-state for PC, FIFO, in-flight and discard counters.
  always_comb begin : comb_next
    fetch_pc_d  = fetch_pc_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    outst_d     = outst_q;
    discard_d   = discard_q;
    fifo_pc_d   = fifo_pc_q;
    fifo_inst_d = fifo_inst_q;
    if (redirect_i) begin
      fetch_pc_d = redirect_tgt;
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      outst_d    = outst_q - CNT_W'(rsp_ok);
      discard_d  = outst_d;
    end else begin
      if (grant) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outst_d = outst_q + CNT_W'(grant) - CNT_W'(rsp_ok);
      if (rsp_ok && (discard_q != '0)) begin
        discard_d = discard_q - CNT_W'(1);
      end
      if (push) begin
        fifo_pc_d[wptr_q]   = rsp_pc;
        fifo_inst_d[wptr_q] = imem_rdata_i;
        wptr_d              = wptr_q + PTR_W'(1);
      end
      if (pop) begin
        rptr_d = rptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin : seq_state
    if (!rst_n_i) begin
      fetch_pc_q <= {RESET_PC[31:2], 2'b00};
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      outst_q    <= '0;
      discard_q  <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        fifo_pc_q[i]   <= '0;
        fifo_inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      outst_q     <= outst_d;
      discard_q   <= discard_d;
      fifo_pc_q   <= fifo_pc_d;
      fifo_inst_q <= fifo_inst_d;
    end
  end

endmodule

// File: tb/tb_my_ifetch.sv
// Bench for my_ifetch: per-cycle vector table plus hand sequences for the
// misaligned redirect and mid-stream reset. A queue-based memory model grants
// as told and answers in order after a per-request latency.
module tb_my_ifetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        fetch_err_o;

  always #5 clk = ~clk;

  my_ifetch #(
    .RESET_PC  (32'h0000_0000),
    .FIFO_DEPTH(2),
    .NOP_INST  (NOP)
  ) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .redirect_i   (redirect_i),
    .redirect_pc_i(redirect_pc_i),
    .id_ready_i   (id_ready_i),
    .inst_valid_o (inst_valid_o),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .fetch_err_o  (fetch_err_o)
  );

  typedef struct {
    logic        rdy;
    logic        gnt;
    logic        redir;
    logic [31:0] rpc;
    int          lat;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    int          ready;
  } rsp_t;

  localparam int NVEC = 33;
  vec_t vecs [NVEC];
  rsp_t mem_q [$];
  int   cyc;
  int   cur_lat;
  int   n_checks;
  int   n_fail;

  // Memory contents: two fixed words at the start, address-derived elsewhere.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h0010_0113;
    return {a[23:0], 8'h93};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic check_outputs(input logic req, input logic [31:0] addr, input logic valid,
                               input logic [31:0] pc, input logic err);
    check("imem_req", 32'(imem_req_o), 32'(req));
    check("imem_addr", imem_addr_o, addr);
    check("inst_valid", 32'(inst_valid_o), 32'(valid));
    check("pc", pc_o, valid ? pc : 32'h0);
    check("inst", inst_o, valid ? inst_of(pc) : NOP);
    check("fetch_err", 32'(fetch_err_o), 32'(err));
  endtask

  // Drive one cycle's inputs (memory response from the model) and wait to mid-cycle.
  task automatic apply(input logic rdy, input logic gnt, input logic redir,
                       input logic [31:0] rpc, input int lat);
    id_ready_i    = rdy;
    imem_gnt_i    = gnt;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    cur_lat       = lat;
    if (mem_q.size() > 0 && mem_q[0].ready <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(mem_q[0].addr);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
    end
    @(negedge clk);
  endtask

  // Update the memory model with this cycle's transfers and move past the edge.
  task automatic advance();
    rsp_t r;
    if (imem_rvalid_i) r = mem_q.pop_front();
    if (imem_req_o && imem_gnt_i) begin
      r.addr  = imem_addr_o;
      r.ready = cyc + cur_lat;
      mem_q.push_back(r);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic setv(input int i, input logic rdy, input logic gnt, input logic redir,
                      input logic [31:0] rpc, input int lat, input logic req,
                      input logic [31:0] addr, input logic valid, input logic [31:0] pc);
    vecs[i].rdy = rdy;  vecs[i].gnt = gnt;  vecs[i].redir = redir;
    vecs[i].rpc = rpc;  vecs[i].lat = lat;  vecs[i].exp_req = req;
    vecs[i].exp_addr = addr;  vecs[i].exp_valid = valid;  vecs[i].exp_pc = pc;
  endtask

  initial begin
    n_checks      = 0;
    n_fail        = 0;
    cyc           = 0;
    cur_lat       = 1;
    rst_n_i       = 1'b0;
    id_ready_i    = 1'b1;
    imem_gnt_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);

    //   idx rdy gnt red rpc        lat req addr        vld pc
    setv( 0, 1, 1, 0, 32'h0,     1, 1, 32'h000, 0, 32'h000);
    setv( 1, 1, 1, 0, 32'h0,     1, 1, 32'h004, 0, 32'h000);
    setv( 2, 1, 1, 0, 32'h0,     1, 1, 32'h008, 1, 32'h000);
    setv( 3, 1, 1, 0, 32'h0,     1, 1, 32'h00C, 1, 32'h004);
    setv( 4, 1, 1, 0, 32'h0,     1, 1, 32'h010, 1, 32'h008);
    setv( 5, 0, 1, 0, 32'h0,     1, 0, 32'h014, 1, 32'h00C);
    setv( 6, 0, 1, 0, 32'h0,     1, 0, 32'h014, 1, 32'h00C);
    setv( 7, 0, 1, 0, 32'h0,     1, 0, 32'h014, 1, 32'h00C);
    setv( 8, 0, 1, 0, 32'h0,     1, 0, 32'h014, 1, 32'h00C);
    setv( 9, 0, 1, 0, 32'h0,     1, 0, 32'h014, 1, 32'h00C);
    setv(10, 1, 1, 0, 32'h0,     1, 1, 32'h014, 1, 32'h00C);
    setv(11, 1, 1, 0, 32'h0,     1, 1, 32'h018, 1, 32'h010);
    setv(12, 1, 1, 0, 32'h0,     1, 1, 32'h01C, 1, 32'h014);
    setv(13, 1, 0, 0, 32'h0,     1, 1, 32'h020, 1, 32'h018);
    setv(14, 1, 0, 0, 32'h0,     1, 1, 32'h020, 1, 32'h01C);
    setv(15, 1, 0, 0, 32'h0,     1, 1, 32'h020, 0, 32'h000);
    setv(16, 1, 1, 0, 32'h0,     1, 1, 32'h020, 0, 32'h000);
    setv(17, 1, 1, 0, 32'h0,     1, 1, 32'h024, 0, 32'h000);
    setv(18, 1, 1, 0, 32'h0,     1, 1, 32'h028, 1, 32'h020);
    setv(19, 1, 1, 0, 32'h0,     1, 1, 32'h02C, 1, 32'h024);
    setv(20, 1, 1, 0, 32'h0,     3, 1, 32'h030, 1, 32'h028);
    setv(21, 1, 1, 0, 32'h0,     3, 1, 32'h034, 1, 32'h02C);
    setv(22, 1, 1, 1, 32'h100,   3, 0, 32'h038, 0, 32'h000);
    setv(23, 1, 1, 0, 32'h0,     3, 0, 32'h100, 0, 32'h000);
    setv(24, 1, 1, 0, 32'h0,     1, 1, 32'h100, 0, 32'h000);
    setv(25, 1, 1, 0, 32'h0,     1, 1, 32'h104, 0, 32'h000);
    setv(26, 1, 1, 0, 32'h0,     1, 1, 32'h108, 1, 32'h100);
    setv(27, 1, 1, 0, 32'h0,     1, 1, 32'h10C, 1, 32'h104);
    setv(28, 1, 1, 1, 32'h200,   1, 0, 32'h110, 0, 32'h000);
    setv(29, 1, 1, 0, 32'h0,     1, 1, 32'h200, 0, 32'h000);
    setv(30, 1, 1, 0, 32'h0,     1, 1, 32'h204, 0, 32'h000);
    setv(31, 1, 1, 0, 32'h0,     1, 1, 32'h208, 1, 32'h200);
    setv(32, 1, 1, 0, 32'h0,     1, 1, 32'h20C, 1, 32'h204);

    rst_n_i = 1'b1;
    cyc     = 0;
    for (int i = 0; i < NVEC; i++) begin
      apply(vecs[i].rdy, vecs[i].gnt, vecs[i].redir, vecs[i].rpc, vecs[i].lat);
      check_outputs(vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid, vecs[i].exp_pc, 1'b0);
      advance();
    end

    // Misaligned redirect target.
    apply(1'b1, 1'b1, 1'b1, 32'h102, 1);
    check_outputs(1'b0, 32'h210, 1'b0, 32'h0, 1'b0);
    advance();
`ifdef IFETCH_ALIGN_CHECK_EN
    for (int k = 0; k < 2; k++) begin
      apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
      check_outputs(1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
      advance();
    end
    apply(1'b1, 1'b1, 1'b1, 32'h200, 1);
    check_outputs(1'b0, 32'h100, 1'b0, 32'h0, 1'b1);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h200, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h204, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h208, 1'b1, 32'h200, 1'b0);
    advance();
`else
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h100, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h104, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h108, 1'b1, 32'h100, 1'b0);
    advance();
`endif

    // Asynchronous reset in the middle of a cycle while the FIFO holds data.
    #2;
    rst_n_i = 1'b0;
    #1;
    check_outputs(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    mem_q.delete();
    imem_rvalid_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n_i = 1'b1;
    cyc     = 0;
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h000, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h004, 1'b0, 32'h0, 1'b0);
    advance();
    apply(1'b1, 1'b1, 1'b0, 32'h0, 1);
    check_outputs(1'b1, 32'h008, 1'b1, 32'h000, 1'b0);
    advance();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
